// File: rtl/dds_pkg.sv
// dds_pkg: shared constants, step table and serial-loader state encoding
package dds_pkg;
    localparam int FRAME_LEN = 40;
    localparam logic [7:0] CTRL_BYTE = 8'h00;
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_BIT_LO, S_BIT_HI, S_FQUD} state_t;
    function automatic logic [31:0] step_of(input logic [1:0] sel);
        return sel == 2'd0 ? 32'd1 : sel == 2'd1 ? 32'd34 : sel == 2'd2 ? 32'd344 : 32'd3436;
    endfunction
endpackage

// File: rtl/dds_serial_load.sv
// dds_serial_load: shifts a 40-bit AD9850 frame out on W_CLK/FQ_UD/DATA
module dds_serial_load
    import dds_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic [31:0] word_i,
    output logic        load_o,
    output logic        busy_o,
    output logic        dds_wclk_o,
    output logic        dds_fqud_o,
    output logic        dds_data_o
);
    localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    state_t                 state_q, state_d;
    logic [CW-1:0]          div_q, div_d;
    logic [5:0]             bit_q, bit_d;
    logic [FRAME_LEN-1:0]   shift_q, shift_d;
    logic                   data_q, data_d;
    logic                   busy_q, wclk_q, fqud_q;
    logic                   div_end;
    assign div_end    = div_q == CW'(CLK_DIV - 1);
    assign load_o     = state_q == S_LOAD;
    assign busy_o     = busy_q;
    assign dds_wclk_o = wclk_q;
    assign dds_fqud_o = fqud_q;
    assign dds_data_o = data_q;
    // next state: each phase lasts CLK_DIV cycles; data advances at the end of W_CLK high
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: state_d = start_i ? S_LOAD : S_IDLE;
            S_LOAD: begin
                shift_d = {CTRL_BYTE, word_i};
                bit_d   = '0;
                div_d   = '0;
                data_d  = word_i[0];
                state_d = S_BIT_LO;
            end
            S_BIT_LO: begin
                div_d   = div_end ? '0 : div_q + 1'b1;
                state_d = div_end ? S_BIT_HI : S_BIT_LO;
            end
            S_BIT_HI: begin
                div_d = div_end ? '0 : div_q + 1'b1;
                if (div_end) begin
                    shift_d = shift_q >> 1;
                    data_d  = shift_q[1];
                    bit_d   = bit_q + 6'd1;
                    state_d = bit_q == 6'(FRAME_LEN - 1) ? S_FQUD : S_BIT_LO;
                end
            end
            S_FQUD: begin
                div_d   = div_end ? '0 : div_q + 1'b1;
                state_d = div_end ? S_IDLE : S_FQUD;
            end
            default: state_d = S_IDLE;
        endcase
    end
    // state and registered pin outputs decoded from the next state
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= 1'b0;
            busy_q  <= 1'b0;
            wclk_q  <= 1'b0;
            fqud_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            busy_q  <= state_d != S_IDLE;
            wclk_q  <= state_d == S_BIT_HI;
            fqud_q  <= state_d == S_FQUD;
        end
    end
endmodule

// File: rtl/dds_tune_ctrl.sv
// dds_tune_ctrl: saturating tuning word with step select, reloaded into the DDS on change
module dds_tune_ctrl
    import dds_pkg::*;
#(
    parameter logic [31:0] FREQ_MIN   = 32'h0010_0000,
    parameter logic [31:0] FREQ_MAX   = 32'h6666_6666,
    parameter logic [31:0] FREQ_RESET = 32'h0B85_1EB8,
    parameter int          CLK_DIV    = 2
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        up_i,
    input  logic        down_i,
    input  logic        step_btn_i,
    output logic [31:0] freq_o,
    output logic [1:0]  step_sel_o,
    output logic        busy_o,
    output logic        dds_wclk_o,
    output logic        dds_fqud_o,
    output logic        dds_data_o
);
    logic [31:0] freq_q, freq_d, step, up_val, dn_val;
    logic [32:0] up_sum, dn_lim;
    logic [1:0]  step_q, step_d;
    logic        btn_q, pending_q, pending_d, load;
    assign freq_o     = freq_q;
    assign step_sel_o = step_q;
    // saturating step arithmetic in 33 bits; a fresh change outranks the load's clear of pending
    always_comb begin
        step      = step_of(step_q);
        up_sum    = {1'b0, freq_q} + {1'b0, step};
        dn_lim    = {1'b0, FREQ_MIN} + {1'b0, step};
        up_val    = up_sum > {1'b0, FREQ_MAX} ? FREQ_MAX : up_sum[31:0];
        dn_val    = {1'b0, freq_q} < dn_lim ? FREQ_MIN : freq_q - step;
        freq_d    = (up_i && !down_i) ? up_val : (down_i && !up_i) ? dn_val : freq_q;
        step_d    = (step_btn_i && !btn_q) ? step_q + 2'd1 : step_q;
        pending_d = (freq_d != freq_q) || (pending_q && !load);
    end
    // tuning state; pending starts set so the reset word is loaded automatically
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            freq_q    <= FREQ_RESET;
            step_q    <= 2'd0;
            btn_q     <= 1'b0;
            pending_q <= 1'b1;
        end else begin
            freq_q    <= freq_d;
            step_q    <= step_d;
            btn_q     <= step_btn_i;
            pending_q <= pending_d;
        end
    end
    dds_serial_load #(.CLK_DIV(CLK_DIV)) u_load (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .start_i    (pending_q),
        .word_i     (freq_q),
        .load_o     (load),
        .busy_o     (busy_o),
        .dds_wclk_o (dds_wclk_o),
        .dds_fqud_o (dds_fqud_o),
        .dds_data_o (dds_data_o)
    );
endmodule

// File: tb/tb_dds_tune_ctrl.sv
// tb_dds_tune_ctrl: random and directed tuning stimulus against a behavioural model and a pin-level frame decoder
module tb_dds_tune_ctrl;
    localparam longint MIN   = 64'h0010_0000;
    localparam longint MAX   = 64'h6666_6666;
    localparam longint RST_F = 64'h0B85_1EB8;
    logic clk = 0, rst_n = 0;
    logic up_i = 0, down_i = 0, step_btn_i = 0;
    logic [31:0] freq_o;
    logic [1:0]  step_sel_o;
    logic        busy_o, dds_wclk_o, dds_fqud_o, dds_data_o;
    logic s_up = 0, s_down = 0, s_btn = 0;
    logic [31:0] s_freq;
    logic [1:0]  s_step;
    logic        s_busy, s_wclk, s_fqud, s_data;
    int checks = 0, errors = 0;
    longint m_freq;
    int     m_step;
    logic   m_btn;
    int     steps [4] = '{1, 34, 344, 3436};
    int     frames = 0, rises = 0, blen = 0, flen = 0;
    logic   pbusy = 0, pw = 0, pf = 0, d1 = 0, d2 = 0;
    logic [39:0] cap = '0, last_word = '0;
    logic [31:0] snap = '0;

    always #5 clk = ~clk;

    dds_tune_ctrl dut (
        .clk_i(clk), .rst_n_i(rst_n), .up_i(up_i), .down_i(down_i), .step_btn_i(step_btn_i),
        .freq_o(freq_o), .step_sel_o(step_sel_o), .busy_o(busy_o),
        .dds_wclk_o(dds_wclk_o), .dds_fqud_o(dds_fqud_o), .dds_data_o(dds_data_o)
    );
    dds_tune_ctrl #(.FREQ_MIN(32'h6666_6600), .FREQ_RESET(32'h6666_6661)) u_sat (
        .clk_i(clk), .rst_n_i(rst_n), .up_i(s_up), .down_i(s_down), .step_btn_i(s_btn),
        .freq_o(s_freq), .step_sel_o(s_step), .busy_o(s_busy),
        .dds_wclk_o(s_wclk), .dds_fqud_o(s_fqud), .dds_data_o(s_data)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_frames(input int target);
        int n = 0;
        while (frames < target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("frame_timeout", 64'(frames >= target), 64'd1);
    endtask

    // reference model: spec rules in plain arithmetic, advanced on every clock edge
    always @(posedge clk) begin
        if (!rst_n) begin
            m_freq = RST_F;
            m_step = 0;
            m_btn  = 0;
        end else begin
            if (up_i && !down_i)
                m_freq = (m_freq > MAX - steps[m_step]) ? MAX : m_freq + steps[m_step];
            else if (down_i && !up_i)
                m_freq = (m_freq < MIN + steps[m_step]) ? MIN : m_freq - steps[m_step];
            if (step_btn_i && !m_btn) m_step = (m_step + 1) % 4;
            m_btn = step_btn_i;
        end
    end

    // per-cycle compare of the register outputs against the model
    always @(negedge clk) begin
        if (rst_n) begin
            chk("freq", 64'(freq_o), m_freq);
            chk("step_sel", 64'(step_sel_o), 64'(m_step));
        end
    end

    // pin-level decoder: frame contents, W_CLK count, setup, FQ_UD width, busy length
    always @(negedge clk) begin
        if (!rst_n) begin
            pbusy = 0; pw = 0; pf = 0; d1 = 0; d2 = 0;
            blen = 0; flen = 0; rises = 0; cap = '0;
        end else begin
            if (busy_o && !pbusy) begin
                snap  = m_freq[31:0];
                blen  = 0;
                rises = 0;
            end
            if (busy_o) blen++;
            if (!busy_o && pbusy) chk("busy_len", 64'(blen), 64'd163);
            if (dds_wclk_o && !pw) begin
                chk("data_setup", 64'(dds_data_o == d1 && d1 == d2), 64'd1);
                cap = {dds_data_o, cap[39:1]};
                rises++;
            end
            if (dds_fqud_o) flen++;
            if (!dds_fqud_o && pf) begin
                chk("fqud_len", 64'(flen), 64'd2);
                chk("wclk_rises", 64'(rises), 64'd40);
                chk("frame_word", 64'(cap), {24'h0, 8'h00, snap});
                last_word = cap;
                frames++;
                flen = 0;
            end
            pbusy = busy_o; pw = dds_wclk_o; pf = dds_fqud_o;
            d2 = d1; d1 = dds_data_o;
        end
    end

    initial begin
        int f0, nb, r;
        repeat (3) tick;
        chk("rst_freq", 64'(freq_o), 64'h0B85_1EB8);
        chk("rst_step", 64'(step_sel_o), 64'd0);
        chk("rst_pins", {busy_o, dds_wclk_o, dds_fqud_o, dds_data_o}, 64'd0);
        rst_n = 1;
        tick;
        tick;
        chk("first_busy", 64'(busy_o), 64'd1);
        wait_frames(1);
        chk("first_word", 64'(last_word), 64'h00_0B85_1EB8);
        repeat (5) tick;
        chk("idle_busy", 64'(busy_o), 64'd0);
        // single detent at step 0
        up_i = 1; tick; up_i = 0;
        chk("up1", 64'(freq_o), 64'h0B85_1EB9);
        wait_frames(2);
        chk("up1_word", 64'(last_word), 64'h00_0B85_1EB9);
        // step button presses, up at step 3
        for (int i = 1; i <= 4; i++) begin
            step_btn_i = 1; repeat (20) tick;
            chk("step_press", 64'(step_sel_o), 64'(i % 4));
            step_btn_i = 0; repeat (3) tick;
            if (i == 3) begin
                up_i = 1; tick; up_i = 0;
                chk("up_step3", 64'(freq_o), 64'h0B85_2C25);
            end
        end
        wait_frames(3);
        chk("step3_word", 64'(last_word), 64'h00_0B85_2C25);
        repeat (5) tick;
        // three detents during an active load
        f0 = frames;
        up_i = 1; tick; up_i = 0;
        repeat (40) tick;
        chk("busy_mid", 64'(busy_o), 64'd1);
        for (int i = 0; i < 3; i++) begin
            up_i = 1; tick; up_i = 0;
            repeat (4) tick;
        end
        chk("during_load", 64'(freq_o), 64'h0B85_2C29);
        repeat (500) tick;
        chk("followup_count", 64'(frames), 64'(f0 + 2));
        chk("followup_word", 64'(last_word), 64'h00_0B85_2C29);
        // simultaneous up and down
        up_i = 1; down_i = 1; tick; up_i = 0; down_i = 0;
        nb = 0;
        repeat (200) begin @(negedge clk); if (busy_o) nb++; end
        chk("both_freq", 64'(freq_o), 64'h0B85_2C29);
        chk("both_noload", 64'(nb), 64'd0);
        // saturation on the second instance
        s_btn = 1; repeat (3) tick; s_btn = 0; repeat (3) tick;
        s_up = 1; tick; s_up = 0;
        chk("sat_max", 64'(s_freq), 64'h6666_6666);
        repeat (200) tick;
        s_up = 1; tick; s_up = 0;
        nb = 0;
        repeat (200) begin @(negedge clk); if (s_busy) nb++; end
        chk("sat_max_hold", 64'(s_freq), 64'h6666_6666);
        chk("sat_max_noload", 64'(nb), 64'd0);
        for (int i = 0; i < 2; i++) begin
            s_btn = 1; repeat (3) tick; s_btn = 0; repeat (3) tick;
        end
        chk("sat_step", 64'(s_step), 64'd3);
        s_down = 1; tick; s_down = 0;
        chk("sat_min", 64'(s_freq), 64'h6666_6600);
        repeat (200) tick;
        s_down = 1; tick; s_down = 0;
        nb = 0;
        repeat (200) begin @(negedge clk); if (s_busy) nb++; end
        chk("sat_min_hold", 64'(s_freq), 64'h6666_6600);
        chk("sat_min_noload", 64'(nb), 64'd0);
        // randomized detents and button activity
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 99));
            up_i   = (r < 8) || (r == 20);
            down_i = (r >= 8 && r < 14) || (r == 20);
            if ($urandom_range(0, 24) == 0) step_btn_i = ~step_btn_i;
            tick;
        end
        up_i = 0; down_i = 0; step_btn_i = 0;
        repeat (400) tick;
        chk("rand_idle", 64'(busy_o), 64'd0);
        chk("rand_last_word", 64'(last_word), {24'h0, 8'h00, m_freq[31:0]});
        // reset in the middle of a frame
        up_i = 1; tick; up_i = 0;
        nb = 0;
        while (rises < 20 && nb < 400) begin @(negedge clk); nb++; end
        chk("bit20_reached", 64'(rises >= 20), 64'd1);
        #1 rst_n = 0;
        #1;
        chk("midrst_pins", {busy_o, dds_wclk_o, dds_fqud_o, dds_data_o}, 64'd0);
        chk("midrst_freq", 64'(freq_o), 64'h0B85_1EB8);
        f0 = frames;
        repeat (3) tick;
        rst_n = 1;
        wait_frames(f0 + 1);
        chk("reload_word", 64'(last_word), 64'h00_0B85_1EB8);
        chk("reload_step", 64'(step_sel_o), 64'd0);
        repeat (5) tick;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
